// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one valid/ready memory port between
// instruction fetch (port 0) and data access (port 1), with a stall watchdog.
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hdeadbeef
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  grant,
    output logic        timeout
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic          last_r, last_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [1:0]    grant_r, grant_s;
    logic          mem_valid_r, mem_valid_s;
    logic          mem_instr_r, mem_instr_s;
    logic [31:0]   mem_addr_r, mem_addr_s;
    logic [31:0]   mem_wdata_r, mem_wdata_s;
    logic [3:0]    mem_wstrb_r, mem_wstrb_s;
    logic          sel_s;
    logic          resp_s;
    logic [31:0]   resp_data_s;
    logic          timeout_s;

    // On a tie the port that did not win last time is chosen.
    assign sel_s = (m0_valid && m1_valid) ? ~last_r : m1_valid;

    // Next-state, captured request fields and response decode.
    always_comb begin
        state_s     = state_r;
        last_s      = last_r;
        cnt_s       = cnt_r;
        grant_s     = grant_r;
        mem_valid_s = mem_valid_r;
        mem_instr_s = mem_instr_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        mem_wstrb_s = mem_wstrb_r;
        resp_s      = 1'b0;
        resp_data_s = 32'h0000_0000;
        timeout_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    state_s     = BUSY;
                    mem_valid_s = 1'b1;
                    mem_instr_s = sel_s ? m1_instr : m0_instr;
                    mem_addr_s  = sel_s ? m1_addr  : m0_addr;
                    mem_wdata_s = sel_s ? m1_wdata : m0_wdata;
                    mem_wstrb_s = sel_s ? m1_wstrb : m0_wstrb;
                    grant_s     = sel_s ? 2'b10 : 2'b01;
                    last_s      = sel_s;
                    cnt_s       = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    resp_s      = 1'b1;
                    resp_data_s = mem_rdata;
                    state_s     = IDLE;
                    mem_valid_s = 1'b0;
                    grant_s     = 2'b00;
                end else if (cnt_r == CNT_LAST) begin
                    state_s     = ERR;
                    mem_valid_s = 1'b0;
                end else begin
                    cnt_s = cnt_r + CW'(1'b1);
                end
            end
            ERR: begin
                resp_s      = 1'b1;
                resp_data_s = ERR_DATA;
                timeout_s   = 1'b1;
                state_s     = IDLE;
                grant_s     = 2'b00;
            end
            default: begin
                state_s     = IDLE;
                mem_valid_s = 1'b0;
                grant_s     = 2'b00;
            end
        endcase
    end

    // State and request registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            last_r      <= 1'b1;
            cnt_r       <= '0;
            grant_r     <= 2'b00;
            mem_valid_r <= 1'b0;
            mem_instr_r <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            mem_wstrb_r <= 4'h0;
        end else begin
            state_r     <= state_s;
            last_r      <= last_s;
            cnt_r       <= cnt_s;
            grant_r     <= grant_s;
            mem_valid_r <= mem_valid_s;
            mem_instr_r <= mem_instr_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            mem_wstrb_r <= mem_wstrb_s;
        end
    end

    // Completion is steered to the granted port only; rdata reads 0 otherwise.
    always_comb begin
        m0_ready = resp_s & grant_r[0];
        m1_ready = resp_s & grant_r[1];
        if (resp_s && grant_r[0]) begin
            m0_rdata = resp_data_s;
        end else begin
            m0_rdata = 32'h0000_0000;
        end
        if (resp_s && grant_r[1]) begin
            m1_rdata = resp_data_s;
        end else begin
            m1_rdata = 32'h0000_0000;
        end
    end

    assign mem_valid = mem_valid_r;
    assign mem_instr = mem_instr_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_wstrb = mem_wstrb_r;
    assign grant     = grant_r;
    assign timeout   = timeout_s;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the core's single `mem_*` memory port between two requesters: instruction fetch on port 0 and data load/store on port 1. It sits between the requesters and the memory model or controller. Each grant runs one complete valid/ready transaction. A watchdog ends any transaction the memory never answers by returning an error word.

## Interface
- `TIMEOUT`, default 16: maximum number of cycles `mem_valid` stays high waiting for `mem_ready`. Legal range is ≥ 2.
- `ERR_DATA`, default 32'hdeadbeef: read data returned to the requester on a timeout.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mN_valid`  in  1  request from port N (N = 0, 1); held high until `mN_ready` is seen.
- `mN_instr`  in  1  instruction-fetch flag, passed through to `mem_instr`.
- `mN_addr`  in  32  byte address.
- `mN_wdata`  in  32  write data.
- `mN_wstrb`  in  4  byte write strobes; 0 means read.
- `mN_ready`  out  1  one-cycle completion pulse to port N.
- `mN_rdata`  out  32  read data; valid only while `mN_ready` = 1, otherwise 0.
- `mem_valid`, `mem_instr`, `mem_addr`, `mem_wdata`, `mem_wstrb`  out  1/1/32/32/4  registered downstream request.
- `mem_ready`  in  1  downstream completion pulse.
- `mem_rdata`  in  32  downstream read data.
- `grant`  out  2  one-hot owner of the transaction in flight; 0 when idle.
- `timeout`  out  1  one-cycle pulse when the watchdog fires.

## Operation
- States: IDLE, BUSY, ERR.
- `last` register (1 bit) records the most recently granted port. Its reset value is 1, so port 0 wins the first tie.
- IDLE:
  - If exactly one `mN_valid` is high, grant that port.
  - If both are high, grant the port that is not `last`.
  - On a grant: capture the port's instr/addr/wdata/wstrb into the `mem_*` registers, set `mem_valid` = 1, set `grant`, update `last`, clear `cnt`, go to BUSY.
  - `mem_ready` is ignored in IDLE.
- BUSY:
  - If `mem_ready` = 1: `mN_ready` = 1 and `mN_rdata` = `mem_rdata`, both combinational, for the granted port only. At that edge `mem_valid` ← 0, `grant` ← 0, go to IDLE.
  - Else if `cnt` == `TIMEOUT`-1: go to ERR, `mem_valid` ← 0.
  - Else `cnt` ← `cnt` + 1.
  - If `mem_ready` arrives in the same cycle as `cnt` == `TIMEOUT`-1, `mem_ready` wins.
- ERR (exactly one cycle): granted `mN_ready` = 1, `mN_rdata` = `ERR_DATA`, `timeout` = 1. Next state is IDLE and `grant` ← 0.
- `cnt` width is $clog2(TIMEOUT).
- Request fields are captured at grant, so later changes on `mN_*` inputs do not disturb the transaction in flight.
- The non-granted port's `mN_ready` stays 0 throughout. Its request waits and is never dropped.
- Reset assertion (async, at any time, including mid-BUSY or mid-ERR):
  - All outputs go to 0 immediately.
  - State → IDLE, `last` → 1, `cnt` → 0.
  - A `mem_ready` that arrives after reset releases, while still in IDLE, is ignored.

## Timing
- Edge E0 samples `mN_valid` = 1 in IDLE. After E0: `mem_valid` = 1 and `grant` is set.
- A memory with one-cycle response samples the request at E1 and raises `mem_ready` after E1. `mN_ready` is high during cycle E1–E2.
- At E2 the requester drops `mN_valid` and the arbiter drops `mem_valid`.
- Cycle E2–E3 is IDLE; E3 can grant the next request.
- Throughput: one transaction per 3 cycles with a one-cycle memory.
- Timeout case: `mem_valid` is high for exactly `TIMEOUT` cycles, then ERR lasts one cycle. Error response arrives `TIMEOUT`+1 cycles after grant.
- Under continuous requests from both ports, grants alternate 0, 1, 0, 1, …

## Test plan
- Reset: hold `reset` = 0 with both `mN_valid` = 1 → every output is 0. Release reset, then m0 reads addr 0 (memory word 32'h3fc00093) → `grant` = 01 after the first edge, `m0_ready` pulse 2 cycles later, `m0_rdata` = 32'h3fc00093.
- Write then read: m1 writes addr 0x3fc, wstrb 4'hf, wdata 5. Then m1 reads 0x3fc → `m1_rdata` = 5, `mem_instr` = 0 on both transactions.
- Byte write: memory word at 0x10 = 32'h11223344. m1 writes wstrb 4'b0010, wdata 32'h0000ab00. Read-back returns 32'h1122ab44.
- Contention: both ports request from the first edge after reset and re-request immediately after each ready → grant order 0, 1, 0, 1. Each port is served every 6 cycles.
- Timeout: m1 reads addr 0x400 (unmapped, memory never answers) → `mem_valid` high for 16 cycles, then `m1_ready` = 1, `m1_rdata` = 32'hdeadbeef, and `timeout` = 1 for one cycle. A following m0 fetch completes normally.
- Mid-transaction reset: assert reset in the cycle after a grant → `mem_valid` and `grant` are 0 immediately. The late `mem_ready` pulse produces no `mN_ready`. After release, m0 wins the first tie.
